mem_stage_access: RTL and testbench
===================================

// Module: mem_stage_access
// PURPOSE
//  MEM pipeline stage: consumes the EXE/MEM register outputs and performs data-memory loads/stores
//  over a req/ack handshake. Stalls upstream stages while an access is outstanding.
//  Provides the MEM/WB register outputs consumed by write-back.
// PARAMETERS
//  DATA_W    32   data/address width
//  DEST_W    5    register-file index width
//  MAX_WAIT  15   ack-timeout limit in cycles; range 1..255
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  WB_EN_in       in   1       write-back enable from EXE/MEM
//  MEM_R_EN_in    in   1       load request
//  MEM_W_EN_in    in   1       store request
//  PC_in          in   DATA_W  instruction PC
//  ALU_result_in  in   DATA_W  memory address, or ALU value for non-memory ops
//  ST_val_in      in   DATA_W  store data
//  Dest_in        in   DEST_W  destination register
//  stall          out  1       freeze PC, IF/ID and EXE/MEM registers (combinational)
//  mem_req        out  1       memory request, registered
//  mem_we         out  1       1 = store, registered
//  mem_addr       out  DATA_W  word address {ALU_result_in[31:2],2'b00}, registered
//  mem_wdata      out  DATA_W  store data, registered
//  mem_rdata      in   DATA_W  load data; valid only while mem_ack=1
//  mem_ack        in   1       access complete; 1-cycle pulse
//  WB_EN          out  1       MEM/WB write-back enable
//  MEM_R_EN       out  1       MEM/WB mux select: 1 = use MEM_result
//  PC_out         out  DATA_W  MEM/WB PC
//  ALU_result     out  DATA_W  MEM/WB ALU value
//  MEM_result     out  DATA_W  MEM/WB load data
//  Dest           out  DEST_W  MEM/WB destination
//  mem_err        out  1       sticky timeout flag
//  align_err      out  1       1-cycle misalignment pulse
// BEHAVIOUR
//  - Reset (rst=0): all outputs 0; state IDLE; wait counter 0; mem_err cleared.
//  - FSM states: IDLE and WAIT.
//  - IDLE, memory op (R|W):
//      - next edge: mem_req=1, mem_we=W, and address/data registered; go to WAIT.
//      - MEM/WB loads a bubble (WB_EN=0, other fields hold).
//  - IDLE, no memory op: MEM/WB loads inputs at the next edge; latency 1 cycle; no stall.
//  - R and W both set: treated as a store; MEM_R_EN out=0.
//  - WAIT:
//      - mem_req/addr/wdata held stable.
//      - wait counter increments each cycle.
//  - WAIT, mem_ack=1:
//      - MEM/WB captures inputs, with MEM_result=mem_rdata on a load (hold otherwise).
//      - mem_req drops at the next edge; return to IDLE; counter cleared.
//  - stall = (IDLE & (R|W)) | (WAIT & ~mem_ack).
//      - stall is low in the ack cycle, so the upstream stage advances on the same edge.
//  - Timeout: counter reaches MAX_WAIT with no ack:
//      - drop mem_req and set mem_err (sticky until reset).
//      - retire the op with WB_EN=0 and MEM_result=0; return to IDLE.
//      - mem_ack arriving in IDLE is ignored.
//  - Store ops never write back data: WB_EN passes through WB_EN_in (decode keeps it 0).
//  - rst asserted mid-access: mem_req drops immediately (async); the access is abandoned.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - memory op with ALU_result_in[1:0]!=0: no request, no stall.
//    - align_err pulses 1 cycle; MEM/WB loads the op with WB_EN=0.
//  MEM_ALIGN_CHECK_EN undefined:
//    - low address bits are truncated silently; align_err tied 0.
//    - port list identical in both builds.
// STRUCTURE
//  - Shared package mem_stage_pkg holds:
//      - state enum {IDLE, WAIT}
//      - DEST_W and the default MAX_WAIT
//      - wait-counter width constant (8 bits)
//  - One sub-module, mem_wb_registers:
//      - holds the WB_EN/MEM_R_EN/PC/ALU/MEM/Dest flops.
//      - has a load enable and a bubble input.
//  - The FSM and handshake live in mem_stage_access.
// TESTING
//  1. Non-memory op: WB_EN_in=1, ALU_result_in=0x1234, Dest_in=7 -> next edge WB_EN=1,
//     ALU_result=0x1234, Dest=7; stall never high.
//  2. Load addr 0x100, ack after 3 cycles with rdata=0xDEADBEEF:
//     - stall high 4 cycles; mem_addr=0x100 and mem_we=0 for the whole access.
//     - MEM_result=0xDEADBEEF and MEM_R_EN=1 after the ack edge.
//  3. Store addr 0x200, data 0xCAFE, ack after 1 cycle:
//     - mem_we=1, mem_wdata=0xCAFE; stall high 2 cycles; WB_EN=0.
//  4. Load with no ack, MAX_WAIT=15:
//     - mem_req drops after 15 WAIT cycles; mem_err=1 and stays 1; WB_EN=0.
//     - a later ack is ignored.
//  5. rst pulsed low during WAIT:
//     - mem_req, stall and all outputs go 0 without a clock edge.
//     - after release, the next op proceeds normally.
//  6. MEM_ALIGN_CHECK_EN build, load addr 0x102:
//     - no mem_req; align_err=1 for 1 cycle; WB_EN=0; no stall.
//     Non-EN build, same stimulus: mem_addr=0x100.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and sizing constants for the MEM stage.
package mem_stage_pkg;
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int MEM_DEST_W   = 5;
    localparam int MEM_MAX_WAIT = 15;
    localparam int WAIT_CNT_W   = 8;
endpackage

// File: rtl/mem_wb_registers.sv
// mem_wb_registers: MEM/WB pipeline register with load enable and bubble insertion.
module mem_wb_registers #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic              mem_load,
    input  logic              wb_en_d,
    input  logic              mem_r_en_d,
    input  logic [DATA_W-1:0] pc_d,
    input  logic [DATA_W-1:0] alu_d,
    input  logic [DATA_W-1:0] mem_d,
    input  logic [DEST_W-1:0] dest_d,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] alu,
    output logic [DATA_W-1:0] mem_result,
    output logic [DEST_W-1:0] dest
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            pc         <= '0;
            alu        <= '0;
            mem_result <= '0;
            dest       <= '0;
        end else if (bubble) begin
            wb_en <= 1'b0;
        end else if (load) begin
            wb_en    <= wb_en_d;
            mem_r_en <= mem_r_en_d;
            pc       <= pc_d;
            alu      <= alu_d;
            dest     <= dest_d;
            if (mem_load) mem_result <= mem_d;
        end
    end
endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM stage issuing loads/stores over req/ack with timeout and stall.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses with an align_err pulse.
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEST_W   = MEM_DEST_W,
    parameter int MAX_WAIT = MEM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] MEM_result,
    output logic [DEST_W-1:0] Dest,
    output logic              mem_err,
    output logic              align_err
);
    state_t                state, state_next;
    logic [WAIT_CNT_W-1:0] cnt, cnt_next;
    logic mem_op, is_load, misal, idle, in_wait, start, ack_hit, timeout;

    assign mem_op  = MEM_R_EN_in | MEM_W_EN_in;
    assign is_load = MEM_R_EN_in & ~MEM_W_EN_in;
    assign idle    = (state == IDLE);
    assign in_wait = (state == WAIT);
    assign start   = idle & mem_op & ~misal;
    assign ack_hit = in_wait & mem_ack;
    assign timeout = in_wait & ~mem_ack & (cnt == WAIT_CNT_W'(MAX_WAIT - 1));
    // Gated by rst so the upstream freeze releases the instant reset asserts.
    assign stall   = rst & (start | (in_wait & ~mem_ack));

`ifdef MEM_ALIGN_CHECK_EN
    assign misal = mem_op & |ALU_result_in[1:0];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) align_err <= 1'b0;
        else      align_err <= idle & misal;
    end
`else
    assign misal     = 1'b0;
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        if (start) state_next = WAIT;
        else if (ack_hit | timeout) state_next = IDLE;
        else if (in_wait) cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= MEM_W_EN_in;
                mem_addr  <= {ALU_result_in[DATA_W-1:2], 2'b00};
                mem_wdata <= ST_val_in;
            end else if (ack_hit | timeout) begin
                mem_req <= 1'b0;
            end
            if (timeout) mem_err <= 1'b1;
        end
    end

    mem_wb_registers #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_mem_wb (
        .clk        (clk),
        .rst_n      (rst),
        .load       ((idle & ~start) | ack_hit | timeout),
        .bubble     (start),
        .mem_load   ((ack_hit & is_load) | timeout),
        .wb_en_d    (WB_EN_in & ~misal & ~timeout),
        .mem_r_en_d (is_load),
        .pc_d       (PC_in),
        .alu_d      (ALU_result_in),
        .mem_d      (timeout ? '0 : mem_rdata),
        .dest_d     (Dest_in),
        .wb_en      (WB_EN),
        .mem_r_en   (MEM_R_EN),
        .pc         (PC_out),
        .alu        (ALU_result),
        .mem_result (MEM_result),
        .dest       (Dest)
    );
endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed vectors and handshake sequences for mem_stage_access.
// Honours MEM_ALIGN_CHECK_EN to pick the matching misalignment expectations.
module tb_mem_stage_access;
    logic        clk = 1'b0, rst = 1'b0;
    logic        wb_en_in = 0, r_en_in = 0, w_en_in = 0, mem_ack = 0;
    logic [31:0] pc_in = 0, alu_in = 0, st_in = 0, mem_rdata = 0;
    logic [4:0]  dest_in = 0;
    logic        stall, mem_req, mem_we, wb_en, mem_r_en, mem_err, align_err;
    logic [31:0] mem_addr, mem_wdata, pc_out, alu_out, mem_result;
    logic [4:0]  dest;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_stage_access dut (
        .clk(clk), .rst(rst), .WB_EN_in(wb_en_in), .MEM_R_EN_in(r_en_in), .MEM_W_EN_in(w_en_in),
        .PC_in(pc_in), .ALU_result_in(alu_in), .ST_val_in(st_in), .Dest_in(dest_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .WB_EN(wb_en), .MEM_R_EN(mem_r_en), .PC_out(pc_out), .ALU_result(alu_out),
        .MEM_result(mem_result), .Dest(dest), .mem_err(mem_err), .align_err(align_err)
    );

    typedef struct {
        logic        wb;
        logic [31:0] pc, alu;
        logic [4:0]  dst;
        logic        exp_wb;
        logic [31:0] exp_pc, exp_alu;
        logic [4:0]  exp_dst;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wb, r, w, input logic [31:0] pc, alu, st, input logic [4:0] d);
        wb_en_in = wb; r_en_in = r; w_en_in = w; pc_in = pc; alu_in = alu; st_in = st; dest_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        int sc, n;
        vt[0] = '{1'b1, 32'h10, 32'h1234,     5'd7,  1'b1, 32'h10, 32'h1234,     5'd7};
        vt[1] = '{1'b1, 32'h14, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'h14, 32'hFFFF_FFFF, 5'd31};
        vt[2] = '{1'b0, 32'h18, 32'hA5A5_0003, 5'd1,  1'b0, 32'h18, 32'hA5A5_0003, 5'd1};
        vt[3] = '{1'b1, 32'h1C, 32'h0,         5'd0,  1'b1, 32'h1C, 32'h0,         5'd0};

        #2;
        chk("reset mem_req", mem_req, 0);
        chk("reset WB_EN", wb_en, 0);
        chk("reset mem_err", mem_err, 0);
        chk("reset stall", stall, 0);
        #10 rst = 1'b1;
        step();

        // Non-memory ops flow straight through with one cycle of latency.
        for (int i = 0; i < 4; i++) begin
            drive(vt[i].wb, 0, 0, vt[i].pc, vt[i].alu, 32'h0, vt[i].dst);
            #1;
            chk($sformatf("v%0d stall", i), stall, 0);
            step();
            chk($sformatf("v%0d WB_EN", i), wb_en, vt[i].exp_wb);
            chk($sformatf("v%0d PC", i), pc_out, vt[i].exp_pc);
            chk($sformatf("v%0d ALU", i), alu_out, vt[i].exp_alu);
            chk($sformatf("v%0d Dest", i), dest, vt[i].exp_dst);
            chk($sformatf("v%0d MEM_R_EN", i), mem_r_en, 0);
            chk($sformatf("v%0d align_err", i), align_err, 0);
        end

        // Load, ack after 3 WAIT cycles.
        sc = 0;
        drive(1, 1, 0, 32'h40, 32'h100, 32'h0, 5'd3);
        #1; sc += int'(stall);
        step(); sc += int'(stall);
        chk("ld req", mem_req, 1);
        chk("ld addr", mem_addr, 32'h100);
        chk("ld we", mem_we, 0);
        chk("ld bubble WB_EN", wb_en, 0);
        step(); sc += int'(stall);
        chk("ld addr hold", mem_addr, 32'h100);
        step(); sc += int'(stall);
        chk("ld addr hold2", mem_addr, 32'h100);
        chk("ld we hold", mem_we, 0);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld ack stall", stall, 0);
        step();
        mem_ack = 0; nop();
        chk("ld stall cycles", sc, 4);
        chk("ld MEM_result", mem_result, 32'hDEAD_BEEF);
        chk("ld MEM_R_EN", mem_r_en, 1);
        chk("ld WB_EN", wb_en, 1);
        chk("ld Dest", dest, 3);
        chk("ld req drop", mem_req, 0);

        // Store, ack after 1 WAIT cycle.
        sc = 0;
        drive(0, 0, 1, 32'h44, 32'h200, 32'hCAFE, 5'd0);
        #1; sc += int'(stall);
        step(); sc += int'(stall);
        chk("st we", mem_we, 1);
        chk("st wdata", mem_wdata, 32'hCAFE);
        chk("st addr", mem_addr, 32'h200);
        mem_ack = 1;
        #1;
        chk("st ack stall", stall, 0);
        step();
        mem_ack = 0; nop();
        chk("st stall cycles", sc, 2);
        chk("st WB_EN", wb_en, 0);
        chk("st MEM_result hold", mem_result, 32'hDEAD_BEEF);

        // R and W together behave as a store.
        drive(0, 1, 1, 32'h48, 32'h500, 32'h77, 5'd2);
        #1;
        step();
        chk("rw we", mem_we, 1);
        chk("rw wdata", mem_wdata, 32'h77);
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        #1;
        step();
        mem_ack = 0; nop();
        chk("rw MEM_R_EN", mem_r_en, 0);
        chk("rw MEM_result hold", mem_result, 32'hDEAD_BEEF);

        // Load with no ack times out after MAX_WAIT cycles.
        drive(1, 1, 0, 32'h4C, 32'h300, 32'h0, 5'd4);
        #1;
        step();
        n = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            n++;
            step();
        end
        nop();
        chk("to req cycles", n, 15);
        chk("to mem_err", mem_err, 1);
        chk("to WB_EN", wb_en, 0);
        chk("to MEM_result", mem_result, 0);
        step();
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        #1;
        step();
        mem_ack = 0;
        chk("late ack req", mem_req, 0);
        chk("late ack MEM_result", mem_result, 0);
        chk("mem_err sticky", mem_err, 1);

        // Reset asserted mid-access clears everything without a clock edge.
        drive(1, 1, 0, 32'h50, 32'h400, 32'h0, 5'd5);
        #1;
        step();
        chk("rs req before", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("rs mem_req", mem_req, 0);
        chk("rs stall", stall, 0);
        chk("rs ALU", alu_out, 0);
        chk("rs Dest", dest, 0);
        chk("rs mem_err", mem_err, 0);
        chk("rs MEM_result", mem_result, 0);
        @(negedge clk) rst = 1'b1;
        step();
        chk("post rs req", mem_req, 1);
        chk("post rs addr", mem_addr, 32'h400);
        mem_ack = 1; mem_rdata = 32'h600D;
        #1;
        step();
        mem_ack = 0; nop();
        chk("post rs MEM_result", mem_result, 32'h600D);
        chk("post rs WB_EN", wb_en, 1);
        chk("post rs Dest", dest, 5);

        // Misaligned load.
        drive(1, 1, 0, 32'h54, 32'h102, 32'h0, 5'd9);
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        chk("al stall", stall, 0);
        step();
        nop();
        chk("al req", mem_req, 0);
        chk("al align_err", align_err, 1);
        chk("al WB_EN", wb_en, 0);
        chk("al Dest", dest, 9);
        step();
        chk("al pulse end", align_err, 0);
`else
        chk("al stall", stall, 1);
        step();
        chk("al addr trunc", mem_addr, 32'h100);
        chk("al req", mem_req, 1);
        chk("al align_err", align_err, 0);
        mem_ack = 1; mem_rdata = 32'h0;
        #1;
        step();
        mem_ack = 0; nop();
        chk("al req drop", mem_req, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
